// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, a single output slot
// toward decode, and redirect handling that discards in-flight responses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   req_pc_q, req_pc_d;
  logic              id_valid_d;
  logic [XLEN-1:0]   id_instr_d;
  logic [XLEN-1:0]   id_pc_d;
  logic              req_fire;

  assign imem_addr = pc_q;

  // Next-state, request generation and output-slot update; redirect wins over everything.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    req_pc_d       = req_pc_q;
    id_valid_d     = id_valid & ~id_ready;
    id_instr_d     = id_instr;
    id_pc_d        = id_pc;
    imem_req_valid = !rst && (state_q == S_REQ) && !redirect_valid && (!id_valid || id_ready);
    req_fire       = imem_req_valid && imem_req_ready;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      id_valid_d = 1'b0;
      case (state_q)
        S_WAIT:  state_d = imem_resp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_resp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          // Slot is guaranteed empty here, so the response always lands.
          if (imem_resp_valid) begin
            id_instr_d = imem_rdata;
            id_pc_d    = req_pc_q;
            id_valid_d = 1'b1;
            state_d    = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end

    if (!id_valid_d) id_instr_d = NOP_INSTR;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      id_valid <= id_valid_d;
      id_instr <= id_instr_d;
      id_pc    <= id_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: memory responder, scoreboard of expected
// decode-side instructions, and directed redirect/stall/reset scenarios.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr, id_pc;

  logic        w_req_valid, w_req_ready, w_resp_valid, w_redirect, w_id_valid, w_id_ready;
  logic [31:0] w_addr, w_rdata, w_redirect_pc, w_id_instr, w_id_pc;

  fetch_stage u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_resp_valid(w_resp_valid), .imem_rdata(w_rdata),
    .redirect_valid(w_redirect), .redirect_pc(w_redirect_pc),
    .id_valid(w_id_valid), .id_ready(w_id_ready), .id_instr(w_id_instr), .id_pc(w_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  exp_t        q[$];
  logic        pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          mem_lat;
  logic        after_rst;

  logic        s_rst, s_req_fire, s_id_fire, s_w_fire;
  logic [31:0] s_addr, s_id_pc, s_id_instr, s_w_addr;
  logic        stall_prev;
  logic [31:0] prev_pc, prev_instr;
  logic [31:0] w_addrs[2];
  int          w_n;

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: sample and score at negedge, then update the memory model after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_rst      = rst;
    s_req_fire = imem_req_valid && imem_req_ready;
    s_addr     = imem_addr;
    s_id_fire  = id_valid && id_ready;
    s_id_pc    = id_pc;
    s_id_instr = id_instr;
    s_w_fire   = w_req_valid && w_req_ready;
    s_w_addr   = w_addr;
    if (!id_valid) check("nop_when_empty", id_instr, NOP);
    if (rst) begin
      check("req_in_reset", 32'(imem_req_valid), 32'd0);
      q.delete();
      pend      = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (redirect_valid || (id_valid && !id_ready))
        check("req_blocked", 32'(imem_req_valid), 32'd0);
      if (stall_prev) begin
        check("stall_valid", 32'(id_valid), 32'd1);
        check("stall_pc", id_pc, prev_pc);
        check("stall_instr", id_instr, prev_instr);
      end
      if (s_id_fire) begin
        if (q.size() == 0) check("sb_unexpected", 32'(q.size()), 32'd1);
        else begin
          e = q.pop_front();
          check("sb_pc", id_pc, e.pc);
          check("sb_instr", id_instr, e.instr);
        end
      end
      if (redirect_valid) q.delete();
      if (s_req_fire) begin
        check("one_outstanding", 32'(pend), 32'd0);
        check("addr_align", 32'(imem_addr[1:0]), 32'd0);
        if (after_rst) begin
          check("first_addr", imem_addr, 32'h0000_0000);
          after_rst = 1'b0;
        end
        q.push_back('{pc: imem_addr, instr: imem_addr ^ KEY});
        pend      = 1'b1;
        pend_addr = imem_addr;
        pend_cnt  = mem_lat;
      end
    end
    stall_prev = !rst && id_valid && !id_ready && !redirect_valid;
    prev_pc    = id_pc;
    prev_instr = id_instr;
    @(posedge clk);
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_resp_valid = 1'b1;
        imem_rdata      = pend_addr ^ KEY;
        pend            = 1'b0;
      end
    end
    w_resp_valid = s_w_fire && !s_rst;
    if (s_w_fire && !s_rst && w_n < 2) begin
      w_addrs[w_n] = s_w_addr;
      w_n++;
    end
  endtask

  task automatic wait_req_fire(input string tag);
    int k = 0;
    do begin tick(); k++; end while (!s_req_fire && k < 100);
    if (!s_req_fire) check({tag, "_timeout"}, 32'(s_req_fire), 32'd1);
  endtask

  task automatic wait_id_fire(input string tag);
    int k = 0;
    do begin tick(); k++; end while (!s_id_fire && k < 100);
    if (!s_id_fire) check({tag, "_timeout"}, 32'(s_id_fire), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [31:0] cap_pc;
    int last_cyc;
    int k;
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    w_req_ready = 1'b1; w_resp_valid = 1'b0; w_rdata = '0; w_redirect = 1'b0;
    w_redirect_pc = '0; w_id_ready = 1'b1;
    pend = 1'b0; pend_cnt = 0; pend_addr = '0; mem_lat = 1; after_rst = 1'b0;
    stall_prev = 1'b0; prev_pc = '0; prev_instr = '0; w_n = 0; last_cyc = 0;

    // Reset state
    tick(); tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, NOP);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    rst = 1'b0;

    // Streaming: one instruction every two cycles, sequential PCs
    for (int i = 0; i < 8; i++) begin
      wait_id_fire("seq");
      check("seq_pc", s_id_pc, 32'(4 * i));
      check("seq_instr", s_id_instr, 32'(4 * i) ^ KEY);
      if (i > 0) check("seq_gap", 32'(cyc - last_cyc), 32'd2);
      last_cyc = cyc;
    end
    check("wrap_count", 32'(w_n >= 2), 32'd1);
    check("wrap_addr0", w_addrs[0], 32'hFFFF_FFFC);
    check("wrap_addr1", w_addrs[1], 32'h0000_0000);

    // Decode stall for five cycles
    id_ready = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!id_valid && k < 100);
    check("stall_seen_valid", 32'(id_valid), 32'd1);
    cap_pc = id_pc;
    repeat (5) tick();
    check("stall_hold_pc", id_pc, cap_pc);
    check("stall_hold_req", 32'(imem_req_valid), 32'd0);
    id_ready = 1'b1;
    wait_id_fire("stall_rel");
    check("stall_rel_pc", s_id_pc, cap_pc);
    wait_id_fire("stall_next");
    check("stall_next_pc", s_id_pc, cap_pc + 32'd4);

    // Redirect while waiting; response arrives later and is dropped
    mem_lat = 3;
    wait_req_fire("rd1");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    mem_lat = 1;
    tick();
    redirect_valid = 1'b0;
    wait_req_fire("rd1_req");
    check("rd1_addr", s_addr, 32'h0000_0100);
    wait_id_fire("rd1_out");
    check("rd1_id_pc", s_id_pc, 32'h0000_0100);
    check("rd1_id_instr", s_id_instr, 32'h0000_0100 ^ KEY);

    // Redirect coincident with the response
    wait_req_fire("rd2");
    check("rd2_resp_now", 32'(imem_resp_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    check("rd2_id_valid", 32'(id_valid), 32'd0);
    wait_req_fire("rd2_req");
    check("rd2_addr", s_addr, 32'h0000_0200);
    wait_id_fire("rd2_out");
    check("rd2_id_pc", s_id_pc, 32'h0000_0200);

    // Reset while waiting; stale response right after release is ignored
    mem_lat = 3;
    wait_req_fire("rst_w");
    tick();
    rst = 1'b1;
    mem_lat = 1;
    tick();
    rst = 1'b0;
    imem_resp_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("stale_req_fire", 32'(s_req_fire), 32'd1);
    check("stale_req_addr", s_addr, 32'h0000_0000);
    check("stale_id_valid", 32'(id_valid), 32'd0);
    wait_id_fire("stale_out");
    check("stale_id_pc", s_id_pc, 32'h0000_0000);
    check("stale_id_instr", s_id_instr, KEY);

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, value driven on id_instr while the output slot is empty.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request; handshake = valid && ready.
REQ-007 imem_addr  output  32  fetch address, word-aligned (bits [1:0] always 00).
REQ-008 imem_resp_valid  input  1  read data valid; no backpressure toward memory.
REQ-009 imem_rdata  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from execute.
REQ-011 redirect_pc  input  32  redirect target; bits [1:0] ignored (forced to 00).
REQ-012 id_valid  output  1  instruction available to decode/imm generation.
REQ-013 id_ready  input  1  decode consumes; handshake = id_valid && id_ready.
REQ-014 id_instr  output  32  instruction word, registered.
REQ-015 id_pc  output  32  address of id_instr, registered.

Function
REQ-016 FSM states SHALL be REQ (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 imem_req_valid SHALL be high iff state==REQ && !redirect_valid && (!id_valid || id_ready); it is a Moore-plus-redirect term with no dependency on imem_req_ready.
REQ-019 imem_addr SHALL equal the PC register.
REQ-020 On request handshake: PC <= PC + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), req_pc <= PC, state REQ->WAIT.
REQ-021 Invariant: while in WAIT the output slot is empty; the response always has a slot.
REQ-022 In WAIT with imem_resp_valid and no redirect: id_instr <= imem_rdata, id_pc <= req_pc, id_valid <= 1, state -> REQ.
REQ-023 Output handshake clears id_valid next cycle unless refilled the same cycle; id_instr/id_pc SHALL hold stable while id_valid && !id_ready.
REQ-024 Redirect has priority over all other events: PC <= {redirect_pc[31:2],2'b00}; id_valid <= 0; no request is issued that cycle.
REQ-025 Redirect in REQ: state stays REQ.
REQ-026 Redirect in WAIT without imem_resp_valid that cycle: state -> DROP.
REQ-027 Redirect in WAIT with imem_resp_valid the same cycle: response discarded, state -> REQ.
REQ-028 In DROP: imem_resp_valid discards the data, state -> REQ; a redirect in DROP updates PC and state stays DROP (or -> REQ if the response arrives the same cycle).
REQ-029 imem_resp_valid while in REQ SHALL be ignored (covers responses in flight across reset).
REQ-030 When id_valid==0, id_instr SHALL read NOP_INSTR.
REQ-031 Peak throughput with 1-cycle memory and id_ready tied high SHALL be one instruction per 2 cycles.
REQ-032 Response latency from the request handshake is unbounded; the block SHALL wait indefinitely in WAIT/DROP.

Reset
REQ-033 On rst: PC=RESET_PC, state=REQ, req_pc=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0; imem_req_valid low during the reset cycle.
REQ-034 rst SHALL override redirect and any handshake in the same cycle; an outstanding request is abandoned and its late response is ignored per REQ-029.
REQ-035 First request after reset deasserts SHALL use imem_addr=RESET_PC.

Verification
REQ-036 Reset, ready=1, 1-cycle memory returning addr^32'hA5A5_0000, id_ready=1 -> id_pc sequence 0,4,8,... with matching id_instr, one per 2 cycles.
REQ-037 id_ready=0 for 5 cycles with id_valid=1 -> id_instr/id_pc stable, imem_req_valid low throughout, no response loss.
REQ-038 Redirect to 32'h0000_0103 while in WAIT, response 3 cycles later -> response dropped, next imem_addr=32'h0000_0100, id_pc of next valid=32'h0000_0100.
REQ-039 Redirect in the same cycle as imem_resp_valid -> data discarded, id_valid=0 next cycle, next request at the redirect target.
REQ-040 RESET_PC=32'hFFFF_FFFC -> second request address 32'h0000_0000.
REQ-041 rst asserted while in WAIT, stale response the cycle after reset releases -> ignored, id_valid stays 0, request issued at RESET_PC.
